// File: rtl/airpong_pkg.sv
// Shared constants, FSM state encoding and a colour-window helper for the object tracker.
package airpong_pkg;

  localparam int COORD_X_W = 11;
  localparam int COORD_Y_W = 10;
  localparam int SUM_W     = 30;
  localparam int CNT_W     = 20;

  localparam logic [COORD_X_W-1:0] DEF_H_ACTIVE = 11'd1024;
  localparam logic [COORD_Y_W-1:0] DEF_V_ACTIVE = 10'd768;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_CHECK,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } centroid_state_e;

  function automatic logic in_window(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, SUM_W/CNT_W bits, one quotient bit per clock after a load cycle.
module seq_divider
  import airpong_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int STEP_W = $clog2(SUM_W);

  logic [CNT_W:0]   rem_q;
  logic [SUM_W-1:0] quo_q;
  logic [CNT_W-1:0] dvs_q;
  logic [STEP_W-1:0] step_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W:0]   rem_shift;
  logic [CNT_W+1:0] diff;

  // The remainder stays below the divisor, so shifting in the next dividend bit fits CNT_W+1 bits.
  assign rem_shift = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      step_q <= STEP_W'(SUM_W - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (diff[CNT_W+1]) begin
        rem_q <= rem_shift;
        quo_q <= {quo_q[SUM_W-2:0], 1'b0};
      end else begin
        rem_q <= diff[CNT_W:0];
        quo_q <= {quo_q[SUM_W-2:0], 1'b1};
      end
      if (step_q == '0) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        step_q <= step_q - STEP_W'(1);
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/object_centroid.sv
// Colour-window object tracker: per-frame pixel count/coordinate sums, divided at frame end.
// Define SMOOTH_EN to average each new centre with the previous one.
module object_centroid
  import airpong_pkg::*;
#(
  parameter logic [COORD_X_W-1:0] H_ACTIVE   = DEF_H_ACTIVE,
  parameter logic [COORD_Y_W-1:0] V_ACTIVE   = DEF_V_ACTIVE,
  parameter logic [7:0]           R_MIN      = 8'd200,
  parameter logic [7:0]           R_MAX      = 8'd255,
  parameter logic [7:0]           G_MIN      = 8'd0,
  parameter logic [7:0]           G_MAX      = 8'd80,
  parameter logic [7:0]           B_MIN      = 8'd200,
  parameter logic [7:0]           B_MAX      = 8'd255,
  parameter logic [CNT_W-1:0]     MIN_PIXELS = 20'd16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COORD_X_W-1:0] hcount,
  input  logic [COORD_Y_W-1:0] vcount,
  input  logic [23:0]          pixel,
  output logic [COORD_X_W-1:0] x_center,
  output logic [COORD_Y_W-1:0] y_center,
  output logic                 found,
  output logic                 valid
);

  centroid_state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt_q, cnt_hold_q;
  logic [SUM_W-1:0]     sum_x_q, sum_y_q, sum_x_hold_q, sum_y_hold_q;
  logic [COORD_X_W-1:0] qx_q, qx_d, x_center_q, x_center_d;
  logic [COORD_Y_W-1:0] qy_q, qy_d, y_center_q, y_center_d;
  logic                 found_q, found_d, valid_q, valid_d;

  logic                 div_start, div_busy, div_done, div_unused;
  logic [SUM_W-1:0]     div_dividend, div_quotient;

  logic match, frame_end;

  assign match = in_window(pixel[23:16], R_MIN, R_MAX) &&
                 in_window(pixel[15:8],  G_MIN, G_MAX) &&
                 in_window(pixel[7:0],   B_MIN, B_MAX) &&
                 (hcount < H_ACTIVE) && (vcount < V_ACTIVE);

  assign frame_end = (hcount == '0) && (vcount == V_ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      cnt_q        <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      cnt_hold_q   <= '0;
      sum_x_hold_q <= '0;
      sum_y_hold_q <= '0;
    end else begin
      if (frame_end) begin
        cnt_q   <= '0;
        sum_x_q <= '0;
        sum_y_q <= '0;
      end else if (match) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        sum_x_q <= sum_x_q + {{(SUM_W-COORD_X_W){1'b0}}, hcount};
        sum_y_q <= sum_y_q + {{(SUM_W-COORD_Y_W){1'b0}}, vcount};
      end
      // A frame end outside ACCUM drops its snapshot so the division in flight keeps its operands.
      if (frame_end && (state_q == ST_ACCUM)) begin
        cnt_hold_q   <= cnt_q;
        sum_x_hold_q <= sum_x_q;
        sum_y_hold_q <= sum_y_q;
      end
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (cnt_hold_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign div_unused = ^{div_quotient[SUM_W-1:COORD_X_W], div_busy};

`ifdef SMOOTH_EN
  logic [COORD_X_W:0] x_avg;
  logic [COORD_Y_W:0] y_avg;
  assign x_avg = {1'b0, x_center_q} + {1'b0, qx_q};
  assign y_avg = {1'b0, y_center_q} + {1'b0, qy_q};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = sum_x_hold_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    x_center_d   = x_center_q;
    y_center_d   = y_center_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    case (state_q)
      ST_ACCUM: if (frame_end) state_d = ST_CHECK;
      ST_CHECK: begin
        if (cnt_hold_q < MIN_PIXELS) begin
          found_d = 1'b0;
          valid_d = 1'b1;
          state_d = ST_ACCUM;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        div_dividend = sum_y_hold_q;
        if (div_done) begin
          qx_d      = div_quotient[COORD_X_W-1:0];
          div_start = 1'b1;
          state_d   = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          qy_d    = div_quotient[COORD_Y_W-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef SMOOTH_EN
        if (found_q) begin
          x_center_d = x_avg[COORD_X_W:1];
          y_center_d = y_avg[COORD_Y_W:1];
        end else begin
          x_center_d = qx_q;
          y_center_d = qy_q;
        end
`else
        x_center_d = qx_q;
        y_center_d = qy_q;
`endif
        found_d = 1'b1;
        valid_d = 1'b1;
        state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ACCUM;
      qx_q       <= '0;
      qy_q       <= '0;
      x_center_q <= H_ACTIVE >> 1;
      y_center_q <= V_ACTIVE >> 1;
      found_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      x_center_q <= x_center_d;
      y_center_q <= y_center_d;
      found_q    <= found_d;
      valid_q    <= valid_d;
    end
  end

  assign x_center = x_center_q;
  assign y_center = y_center_q;
  assign found    = found_q;
  assign valid    = valid_q;

endmodule
